vga_rx: RTL and testbench

Receiving end of the team's VGA pixel link: samples `hsync`, `vsync` and 12-bit `rgb`, recovers the pixel position from the sync edges, and checks line and frame lengths against the 800×525 geometry. Once it has seen one complete, correctly timed frame, it emits one frame-buffer write per active pixel. Sits between a VGA timing source (loopback or external capture) and the frame-buffer write port; used for self-test and video capture.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_rx_if.sv | 29 ++
 rtl/vga_rx_sync_edge.sv | 25 ++
 rtl/vga_rx.sv | 139 +++++++++++++
 tb/tb_vga_rx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA geometry defaults and receiver state encoding.
package vga_pkg;

   localparam int unsigned VGA_H_TOTAL     = 800;
   localparam int unsigned VGA_V_TOTAL     = 525;
   localparam int unsigned VGA_H_ACT_START = 144;
   localparam int unsigned VGA_H_ACT       = 640;
   localparam int unsigned VGA_V_ACT_START = 35;
   localparam int unsigned VGA_V_ACT       = 480;

   localparam int unsigned CNT_W = 10;
   localparam int unsigned RGB_W = 12;
   localparam int unsigned ERR_W = 8;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/vga_rx_if.sv
// VGA link: sync/pixel input from the timing source, frame-buffer writes and status out.
interface vga_rx_if;
   import vga_pkg::*;

   logic             hsync;
   logic             vsync;
   logic [RGB_W-1:0] rgb;
   logic             pix_we;
   logic [CNT_W-1:0] pix_x;
   logic [CNT_W-1:0] pix_y;
   logic [RGB_W-1:0] pix_data;
   logic             locked;
   logic             frame_start;
   logic             err;
   logic [ERR_W-1:0] err_cnt;

   // Video source side
   modport master (
      output hsync, vsync, rgb,
      input  pix_we, pix_x, pix_y, pix_data, locked, frame_start, err, err_cnt
   );

   // Receiver side
   modport slave (
      input  hsync, vsync, rgb,
      output pix_we, pix_x, pix_y, pix_data, locked, frame_start, err, err_cnt
   );

endinterface

// File: rtl/vga_rx_sync_edge.sv
// Input register plus falling-edge detector; previous value idles high so reset never fakes an edge.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic fall_c
);

   logic q;
   logic prev;

   // Register the raw sync once, keep one cycle of history
   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= 1'b1;
         prev <= 1'b1;
      end else begin
         q    <= din;
         prev <= q;
      end
   end

   assign fall_c = prev & ~q;

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: recovers pixel position from syncs, checks geometry, writes active pixels once locked.
module vga_rx
   import vga_pkg::*;
#(
   parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
   parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
   parameter int unsigned H_ACT_START = VGA_H_ACT_START,
   parameter int unsigned H_ACT       = VGA_H_ACT,
   parameter int unsigned V_ACT_START = VGA_V_ACT_START,
   parameter int unsigned V_ACT       = VGA_V_ACT
) (
   input  logic     clk,
   input  logic     rst,
   vga_rx_if.slave  vid
);

   localparam int unsigned CW = CNT_W;

   logic             hs_fall;
   logic             vs_fall;
   logic             vs_fell;
   logic [RGB_W-1:0] rgb_q;
   logic [CW-1:0]    hpos, vpos, hpos_nxt, vpos_nxt;
   logic             fs_c, viol_c, bad;
   state_t           state, state_nxt;

   logic             pix_we_d, locked_d, fs_d;
   logic [CW-1:0]    pix_x_d, pix_y_d;
   logic [RGB_W-1:0] pix_data_d;
   logic [ERR_W-1:0] err_cnt_d;

   sync_edge u_hs (.clk(clk), .rst(rst), .din(vid.hsync), .fall_c(hs_fall));
   sync_edge u_vs (.clk(clk), .rst(rst), .din(vid.vsync), .fall_c(vs_fall));

   // Pixel register and "vsync fell since the last hsync edge" marker
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q   <= '0;
         vs_fell <= 1'b0;
      end else begin
         rgb_q <= vid.rgb;
         if (hs_fall)      vs_fell <= 1'b0;
         else if (vs_fall) vs_fell <= 1'b1;
      end
   end

   // Position counters and timing-violation detection
   always_comb begin
      hpos_nxt = hpos;
      vpos_nxt = vpos;
      fs_c     = hs_fall & (vs_fell | vs_fall);
      if (hs_fall) begin
         hpos_nxt = '0;
         if (fs_c)                     vpos_nxt = '0;
         else if (vpos != CW'(V_TOTAL)) vpos_nxt = vpos + CW'(1);
      end else if (hpos != CW'(H_TOTAL)) begin
         hpos_nxt = hpos + CW'(1);
      end
      viol_c = (state != SEARCH) &
               ((hs_fall & (hpos != CW'(H_TOTAL - 1))) |
                (~hs_fall & (hpos == CW'(H_TOTAL - 1))) |
                (fs_c & (vpos != CW'(V_TOTAL - 1))));
   end

   // Counter registers and CHECK-window violation memory
   always_ff @(posedge clk) begin
      if (rst) begin
         hpos <= '0;
         vpos <= '0;
         bad  <= 1'b0;
      end else begin
         hpos <= hpos_nxt;
         vpos <= vpos_nxt;
         if (state != CHECK || fs_c) bad <= 1'b0;
         else if (viol_c)            bad <= 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= SEARCH;
      else     state <= state_nxt;
   end

   // Next-state: lock after one clean frame, drop on any violation
   always_comb begin
      state_nxt = state;
      case (state)
         SEARCH: if (fs_c) state_nxt = CHECK;
         CHECK:  if (fs_c && !(bad || viol_c)) state_nxt = LOCKED;
         LOCKED: if (viol_c) state_nxt = SEARCH;
         default: state_nxt = SEARCH;
      endcase
   end

   // Output decode, aligned to the position the registered outputs will show
   always_comb begin
      pix_we_d   = 1'b0;
      pix_x_d    = '0;
      pix_y_d    = '0;
      pix_data_d = '0;
      locked_d   = (state_nxt == LOCKED);
      fs_d       = fs_c & (state_nxt == LOCKED);
      err_cnt_d  = vid.err_cnt;
      if (viol_c && vid.err_cnt != '1) err_cnt_d = vid.err_cnt + ERR_W'(1);
      if (locked_d &&
          hpos_nxt >= CW'(H_ACT_START) && hpos_nxt < CW'(H_ACT_START + H_ACT) &&
          vpos_nxt >= CW'(V_ACT_START) && vpos_nxt < CW'(V_ACT_START + V_ACT)) begin
         pix_we_d   = 1'b1;
         pix_x_d    = hpos_nxt - CW'(H_ACT_START);
         pix_y_d    = vpos_nxt - CW'(V_ACT_START);
         pix_data_d = rgb_q;
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         vid.pix_we      <= 1'b0;
         vid.pix_x       <= '0;
         vid.pix_y       <= '0;
         vid.pix_data    <= '0;
         vid.locked      <= 1'b0;
         vid.frame_start <= 1'b0;
         vid.err         <= 1'b0;
         vid.err_cnt     <= '0;
      end else begin
         vid.pix_we      <= pix_we_d;
         vid.pix_x       <= pix_x_d;
         vid.pix_y       <= pix_y_d;
         vid.pix_data    <= pix_data_d;
         vid.locked      <= locked_d;
         vid.frame_start <= fs_d;
         vid.err         <= viol_c;
         vid.err_cnt     <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx using a reduced 16x8 geometry so full frames stay short.
module tb_vga_rx;

   localparam int HT  = 16;
   localparam int VT  = 8;
   localparam int HAS = 4;
   localparam int HA  = 8;
   localparam int VAS = 2;
   localparam int VA  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vga_rx_if vid ();

   vga_rx #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS),
      .H_ACT(HA), .V_ACT_START(VAS), .V_ACT(VA)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vid(vid)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int cyc = 0;
   int we_cnt = 0, err_pulses = 0, fs_pulses = 0;
   int pix_bad = 0, idle_bad = 0;
   int p00 = 0, p73 = 0, p00_cyc = 0, fs_cyc = 0;
   int drv00 = 0, drv_fs = 0;
   int we0, er0;

   // Cycle counter and output monitor, sampled mid-cycle
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vid.pix_we) begin
         we_cnt++;
         if (vid.pix_data !== {vid.pix_x[3:0], vid.pix_y[3:0], 4'h5} ||
             vid.pix_x >= 10'(HA) || vid.pix_y >= 10'(VA))
            pix_bad++;
         if (vid.pix_x == 10'd0 && vid.pix_y == 10'd0) begin
            p00     = int'(vid.pix_data);
            p00_cyc = cyc;
         end
         if (vid.pix_x == 10'd7 && vid.pix_y == 10'd3) p73 = int'(vid.pix_data);
      end else if (vid.pix_data !== 12'h000) begin
         idle_bad++;
      end
      if (vid.err) err_pulses++;
      if (vid.frame_start) begin
         fs_pulses++;
         fs_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         vid.hsync = 1'b1;
         vid.vsync = 1'b1;
         vid.rgb   = 12'h000;
         tick();
      end
   endtask

   // One line from the reference timing: hsync low for 2 clocks, rgb = {x,y,5} when active
   task automatic drive_line(input int len, input bit vlow, input int line);
      for (int h = 0; h < len; h++) begin
         vid.hsync = (h < 2) ? 1'b0 : 1'b1;
         vid.vsync = vlow ? 1'b0 : 1'b1;
         if (h >= HAS && h < HAS + HA && line >= VAS && line < VAS + VA)
            vid.rgb = {4'(h - HAS), 4'(line - VAS), 4'h5};
         else
            vid.rgb = 12'h000;
         if (line == VAS && h == HAS) drv00 = cyc;
         if (line == 0 && h == 0) drv_fs = cyc;
         tick();
      end
   endtask

   task automatic drive_frame(input int nlines, input int short_line);
      for (int l = 0; l < nlines; l++)
         drive_line((l == short_line) ? HT - 1 : HT, l == 0, l);
   endtask

   initial begin
      vid.hsync = 1'b1;
      vid.vsync = 1'b1;
      vid.rgb   = 12'h000;
      rst       = 1'b1;
      tick(); tick(); tick();

      chk("rst_pix_we",      int'(vid.pix_we), 0);
      chk("rst_pix_x",       int'(vid.pix_x), 0);
      chk("rst_pix_y",       int'(vid.pix_y), 0);
      chk("rst_pix_data",    int'(vid.pix_data), 0);
      chk("rst_locked",      int'(vid.locked), 0);
      chk("rst_frame_start", int'(vid.frame_start), 0);
      chk("rst_err",         int'(vid.err), 0);
      chk("rst_err_cnt",     int'(vid.err_cnt), 0);

      // Clean loopback: lock on the second frame start
      rst = 1'b0;
      idle(5);
      drive_frame(VT, -1);
      chk("check_not_locked", int'(vid.locked), 0);
      drive_frame(VT, -1);
      chk("locked_after_2nd", int'(vid.locked), 1);
      drive_frame(VT, -1);
      chk("locked_frame_c",   int'(vid.locked), 1);
      chk("frame_start_cnt",  fs_pulses, 2);
      chk("writes_2_frames",  we_cnt, 2 * HA * VA);
      chk("pixel_0_0",        p00, 12'h005);
      chk("pixel_7_3",        p73, 12'h735);
      chk("pixel_latency",    p00_cyc - drv00, 2);
      chk("fs_latency",       fs_cyc - drv_fs, 2);
      chk("no_err_clean",     err_pulses, 0);
      chk("err_cnt_clean",    int'(vid.err_cnt), 0);

      // Reset in the middle of an active line
      for (int l = 0; l < 3; l++) drive_line(HT, l == 0, l);
      drive_line(9, 1'b0, 3);
      chk("pre_rst_pix_we", int'(vid.pix_we), 1);
      rst = 1'b1;
      vid.hsync = 1'b1; vid.vsync = 1'b1; vid.rgb = 12'h000;
      tick();
      chk("midrst_pix_we",   int'(vid.pix_we), 0);
      chk("midrst_pix_x",    int'(vid.pix_x), 0);
      chk("midrst_pix_data", int'(vid.pix_data), 0);
      chk("midrst_locked",   int'(vid.locked), 0);
      chk("midrst_fs",       int'(vid.frame_start), 0);
      rst = 1'b0;
      drive_frame(VT, -1);
      chk("relock_check", int'(vid.locked), 0);
      we0 = we_cnt;
      drive_frame(VT, -1);
      drive_frame(VT, -1);
      chk("relock_locked",   int'(vid.locked), 1);
      chk("relock_writes",   we_cnt - we0, 2 * HA * VA);
      chk("relock_no_err",   err_pulses, 0);
      chk("relock_err_cnt",  int'(vid.err_cnt), 0);

      // One short line while locked
      we0 = we_cnt; er0 = err_pulses;
      drive_frame(VT, 3);
      chk("short_err_pulse", err_pulses - er0, 1);
      chk("short_err_cnt",   int'(vid.err_cnt), 1);
      chk("short_unlocked",  int'(vid.locked), 0);
      chk("short_writes",    we_cnt - we0, 2 * HA);
      drive_frame(VT, -1);
      we0 = we_cnt;
      drive_frame(VT, -1);
      drive_frame(VT, -1);
      chk("short_relock",    int'(vid.locked), 1);
      chk("short_relock_we", we_cnt - we0, 2 * HA * VA);

      // hsync stuck high: a single missing-hsync flag
      er0 = err_pulses;
      idle(6 * HT);
      chk("miss_err_pulse", err_pulses - er0, 1);
      chk("miss_err_cnt",   int'(vid.err_cnt), 2);
      chk("miss_unlocked",  int'(vid.locked), 0);

      // Short frame while in CHECK, then a correct frame
      drive_frame(VT - 1, -1);
      chk("shortf_check", int'(vid.locked), 0);
      er0 = err_pulses;
      drive_frame(VT, -1);
      chk("shortf_err",     err_pulses - er0, 1);
      chk("shortf_err_cnt", int'(vid.err_cnt), 3);
      chk("shortf_stay",    int'(vid.locked), 0);
      drive_frame(VT, -1);
      chk("shortf_lock",    int'(vid.locked), 1);

      // 300 bad lines inside a CHECK window saturate the counter
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      er0 = err_pulses;
      drive_line(HT, 1'b1, 0);
      for (int i = 0; i < 300; i++) drive_line(HT - 1, 1'b0, VT);
      drive_line(HT, 1'b0, VT);
      chk("sat_err_pulses", err_pulses - er0, 300);
      chk("sat_err_cnt",    int'(vid.err_cnt), 255);
      chk("sat_unlocked",   int'(vid.locked), 0);

      chk("pixel_values",  pix_bad, 0);
      chk("idle_data_zero", idle_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
